// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_RDWAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } arb_owner_t;

  // Width of the debug starvation counter; MAX_WAIT must fit in it.
  localparam int WAIT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the arbiter.
// slave: the arbiter's view. master: requesters plus memory (the environment).
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_sb;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_we;
  logic          mem_sb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_we, mem_sb, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_we, mem_sb, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating starvation counter: counts lost arbitration cycles for the
// debug port and flags when it has waited long enough to pre-empt the CPU.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX);

  logic [WAIT_W-1:0] cnt;

  // Clear has priority over increment; the count never exceeds MAX.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt < MAX_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt >= MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU load/store
// port (priority) and a debug/loader port. Writes finish in the grant
// cycle; reads hold the memory for a second cycle while data returns.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  arb_state_t    state;
  arb_owner_t    owner;
  logic [AW-1:0] raddr;

  logic is_idle;
  logic in_rd;
  logic wait_sat;
  logic dbg_win;
  logic cpu_win;
  logic rd_cpu;
  logic wait_inc;
  logic wait_clr;

  // Reset suppresses both issue and read-return so nothing leaks out of an
  // aborted read.
  assign is_idle = (state == ARB_IDLE) && !reset;
  assign in_rd   = (state == ARB_RDWAIT) && !reset;
  assign dbg_win = is_idle && bus.dbg_req && (!bus.cpu_req || wait_sat);
  assign cpu_win = is_idle && bus.cpu_req && !dbg_win;
  assign rd_cpu  = in_rd && (owner == OWN_CPU);

  // Debug loses either by arbitration or by sitting behind a CPU read.
  assign wait_inc = bus.dbg_req && ((is_idle && !dbg_win) || rd_cpu);
  assign wait_clr = dbg_win || !bus.dbg_req;

  arb_wait_counter #(
    .MAX (MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .sat   (wait_sat)
  );

  // Read tracking: remember who issued the read and where, for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= OWN_CPU;
      raddr <= '0;
    end else if (state == ARB_RDWAIT) begin
      state <= ARB_IDLE;
    end else if (cpu_win && !bus.cpu_we) begin
      state <= ARB_RDWAIT;
      owner <= OWN_CPU;
      raddr <= bus.cpu_addr;
    end else if (dbg_win && !bus.dbg_we) begin
      state <= ARB_RDWAIT;
      owner <= OWN_DBG;
      raddr <= bus.dbg_addr;
    end
  end

  // Memory-side mux and requester responses; everything idles at zero.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    bus.mem_we     = 1'b0;
    bus.mem_sb     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.cpu_rdata  = '0;
    bus.dbg_gnt    = 1'b0;
    bus.dbg_rvalid = 1'b0;
    bus.dbg_rdata  = '0;

    if (cpu_win) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_sb    = bus.cpu_sb;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dbg_win) begin
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
      bus.dbg_gnt   = 1'b1;
    end else if (in_rd) begin
      bus.mem_addr = raddr;
      if (owner == OWN_CPU) begin
        bus.cpu_rdata = bus.mem_rdata;
      end else begin
        bus.dbg_rvalid = 1'b1;
        bus.dbg_rdata  = bus.mem_rdata;
      end
    end

    // CPU is released only by its own write issue or its read return.
    bus.cpu_stall = bus.cpu_req && !((cpu_win && bus.cpu_we) || rd_cpu);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized CPU and
// debug traffic, all scored against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int TMO      = 200;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(
    .AW       (32),
    .DW       (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory device: 64 words, registered read, optional byte-lane store.
  logic [31:0] tb_mem [64] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_sb) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_addr[1:0] == 2'(b))
            tb_mem[bus.mem_addr[7:2]][b*8 +: 8] <= bus.mem_wdata[7:0];
      end else begin
        tb_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      end
    end
    bus.mem_rdata <= tb_mem[bus.mem_addr[7:2]];
  end

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t gnt_q[$];
  exp_t rv_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_line(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: who is served each cycle follows the priority and
  // starvation rules as plain integers; memory is a word array.
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  initial begin : model
    int          waited;
    int          pend;      // 0 none, 1 CPU read, 2 debug read
    logic [31:0] pend_data;
    logic [31:0] pend_addr;
    exp_t        e;
    waited = 0;
    pend   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        waited = 0;
        pend   = 0;
      end else if (pend != 0) begin
        e = '{cyc: cyc, we: 1'b0, addr: pend_addr, data: pend_data};
        if (pend == 1) begin
          if (bus.cpu_req) cpu_q.push_back(e);
          waited = bus.dbg_req ? ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT) : 0;
        end else begin
          rv_q.push_back(e);
          if (!bus.dbg_req) waited = 0;
        end
        pend = 0;
      end else if (bus.dbg_req && (!bus.cpu_req || waited >= MAX_WAIT)) begin
        gnt_q.push_back('{cyc: cyc, we: bus.dbg_we, addr: bus.dbg_addr, data: bus.dbg_wdata});
        if (bus.dbg_we) begin
          ref_mem[bus.dbg_addr[7:2]] = bus.dbg_wdata;
        end else begin
          pend      = 2;
          pend_addr = bus.dbg_addr;
          pend_data = ref_mem[bus.dbg_addr[7:2]];
        end
        waited = 0;
      end else if (bus.cpu_req) begin
        if (bus.cpu_we) begin
          if (bus.cpu_sb)
            ref_mem[bus.cpu_addr[7:2]][8*bus.cpu_addr[1:0] +: 8] = bus.cpu_wdata[7:0];
          else
            ref_mem[bus.cpu_addr[7:2]] = bus.cpu_wdata;
          cpu_q.push_back('{cyc: cyc, we: 1'b1, addr: bus.cpu_addr, data: 32'h0});
        end else begin
          pend      = 1;
          pend_addr = bus.cpu_addr;
          pend_data = ref_mem[bus.cpu_addr[7:2]];
        end
        waited = bus.dbg_req ? ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT) : 0;
      end else begin
        waited = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
        e = cpu_q.pop_front();
        fail_line("cpu_done_missing", cyc, e.cyc);
      end
      while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
        e = gnt_q.pop_front();
        fail_line("dbg_gnt_missing", cyc, e.cyc);
      end
      while (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
        e = rv_q.pop_front();
        fail_line("dbg_rvalid_missing", cyc, e.cyc);
      end

      if (bus.dbg_gnt) begin
        if (gnt_q.size() == 0) fail_line("dbg_gnt_unexpected", cyc, -1);
        else begin
          e = gnt_q.pop_front();
          check("gnt_cycle", cyc, e.cyc);
          check("gnt_addr", bus.mem_addr, e.addr);
          check("gnt_we", 32'(bus.mem_we), 32'(e.we));
          check("gnt_sb", 32'(bus.mem_sb), 32'h0);
          if (e.we) check("gnt_wdata", bus.mem_wdata, e.data);
        end
      end

      if (bus.dbg_rvalid) begin
        if (rv_q.size() == 0) fail_line("dbg_rvalid_unexpected", cyc, -1);
        else begin
          e = rv_q.pop_front();
          check("rv_cycle", cyc, e.cyc);
          check("rv_data", bus.dbg_rdata, e.data);
        end
      end else begin
        check("dbg_rdata_idle", bus.dbg_rdata, 32'h0);
      end

      if (bus.cpu_req && !bus.cpu_stall) begin
        if (cpu_q.size() == 0) fail_line("cpu_done_unexpected", cyc, -1);
        else begin
          e = cpu_q.pop_front();
          check("cpu_cycle", cyc, e.cyc);
          check("cpu_rdata", bus.cpu_rdata, e.data);
          if (e.we) begin
            check("cpu_st_we", 32'(bus.mem_we), 32'h1);
            check("cpu_st_addr", bus.mem_addr, e.addr);
          end
        end
      end

      if (reset) begin
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_gnt", 32'(bus.dbg_gnt), 32'h0);
        check("rst_rvalid", 32'(bus.dbg_rvalid), 32'h0);
        check("rst_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic sb,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_sb = sb;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic dbg_set(input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
  endtask

  task automatic cpu_agent(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 3) == 0)
          cpu_set(1'b1, 1'b1, 1'b1, 32'($urandom_range(0, 63)), $urandom);
        else
          cpu_set(1'b1, 1'b1, 1'b0, 32'($urandom_range(0, 15)) << 2, $urandom);
      end else begin
        cpu_set(1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 15)) << 2, 32'h0);
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(bus.cpu_req && !bus.cpu_stall) && t < TMO);
      if (t >= TMO) fail_line("cpu_timeout", t, TMO);
      tick();
      bus.cpu_req = 1'b0;
    end
  endtask

  task automatic dbg_agent(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      dbg_set(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(bus.dbg_we ? bus.dbg_gnt : bus.dbg_rvalid) && t < TMO);
      if (t >= TMO) fail_line("dbg_timeout", t, TMO);
      tick();
      bus.dbg_req = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1;
    cpu_set(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    look();
    check("reset_stall", 32'(bus.cpu_stall), 32'h1);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    tick();
    reset = 1'b0;
    bus.cpu_req = 1'b0;

    // CPU word store completes without stall
    cpu_set(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    look();
    check("st_mem_we", 32'(bus.mem_we), 32'h1);
    check("st_mem_addr", bus.mem_addr, 32'h40);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("st_stall", 32'(bus.cpu_stall), 32'h0);
    tick();

    // CPU load: one stall cycle, then data
    cpu_set(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    look();
    check("ld_stall0", 32'(bus.cpu_stall), 32'h1);
    check("ld_addr0", bus.mem_addr, 32'h40);
    tick();
    look();
    check("ld_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("ld_stall1", 32'(bus.cpu_stall), 32'h0);
    check("ld_rd_addr", bus.mem_addr, 32'h40);
    tick();
    bus.cpu_req = 1'b0;

    // Debug write then debug read; CPU load arrives during the read return
    dbg_set(1'b1, 1'b1, 32'h10, 32'h12345678);
    look();
    check("dw_gnt", 32'(bus.dbg_gnt), 32'h1);
    tick();
    bus.dbg_we = 1'b0;
    look();
    check("dr_gnt", 32'(bus.dbg_gnt), 32'h1);
    tick();
    cpu_set(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    look();
    check("dr_rvalid", 32'(bus.dbg_rvalid), 32'h1);
    check("dr_rdata", bus.dbg_rdata, 32'h12345678);
    check("dr_cpu_stall", 32'(bus.cpu_stall), 32'h1);
    tick();
    bus.dbg_req = 1'b0;
    look();
    check("dr_cpu_issue", bus.mem_addr, 32'h40);
    check("dr_cpu_stall2", 32'(bus.cpu_stall), 32'h1);
    tick();
    look();
    check("dr_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    tick();
    bus.cpu_req = 1'b0;

    // Contention: CPU stores win MAX_WAIT times, then debug is forced through
    cpu_set(1'b1, 1'b1, 1'b0, 32'h80, 32'h11110000);
    dbg_set(1'b1, 1'b1, 32'h84, 32'h22220000);
    for (int i = 0; i < MAX_WAIT; i++) begin
      look();
      check("cont_cpu_gnt", 32'(bus.dbg_gnt), 32'h0);
      check("cont_cpu_stall", 32'(bus.cpu_stall), 32'h0);
      tick();
    end
    look();
    check("cont_dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
    check("cont_dbg_stall", 32'(bus.cpu_stall), 32'h1);
    tick();
    bus.dbg_wdata = 32'h33330000;
    look();
    check("cont_cleared", 32'(bus.dbg_gnt), 32'h0);
    tick();
    bus.cpu_req = 1'b0;
    look();
    check("cont_dbg_free", 32'(bus.dbg_gnt), 32'h1);
    tick();
    bus.dbg_req = 1'b0;

    // CPU byte store defers a simultaneous debug write
    cpu_set(1'b1, 1'b1, 1'b1, 32'h43, 32'h000000AB);
    dbg_set(1'b1, 1'b1, 32'h08, 32'h55);
    look();
    check("sb_mem_sb", 32'(bus.mem_sb), 32'h1);
    check("sb_mem_we", 32'(bus.mem_we), 32'h1);
    check("sb_dbg_deferred", 32'(bus.dbg_gnt), 32'h0);
    tick();
    cpu_set(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look();
    check("sb_dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
    tick();
    bus.dbg_req = 1'b0;

    // Reset while a debug read is waiting for data
    dbg_set(1'b1, 1'b0, 32'h10, 32'h0);
    look();
    check("rr_gnt", 32'(bus.dbg_gnt), 32'h1);
    tick();
    reset = 1'b1;
    look();
    check("rr_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    check("rr_mem_addr", bus.mem_addr, 32'h0);
    check("rr_mem_wdata", bus.mem_wdata, 32'h0);
    check("rr_mem_sb", 32'(bus.mem_sb), 32'h0);
    tick();
    reset = 1'b0;
    look();
    check("rr_regnt", 32'(bus.dbg_gnt), 32'h1);
    tick();
    look();
    check("rr_rdata", bus.dbg_rdata, 32'h12345678);
    tick();
    bus.dbg_req = 1'b0;

    // Randomized mixed traffic
    fork
      cpu_agent(150);
      dbg_agent(60);
    join
    repeat (4) tick();

    check("cpu_q_drained", cpu_q.size(), 32'h0);
    check("gnt_q_drained", gnt_q.size(), 32'h0);
    check("rv_q_drained", rv_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipelined MIPS core's load/store port and a debug/loader port. The debug/loader port is used by the bench or a boot loader to preload or inspect data memory.
Sits between the core/debug master and dmem.
Writes complete in the grant cycle. Reads issue, then return data one cycle later.
The CPU has priority; a starvation counter guarantees the debug port is served within MAX_WAIT cycles.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 8, consecutive lost arbitration cycles after which debug wins over CPU (range 1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request (load or store)
cpu_we  in  1  1 = store, 0 = load
cpu_sb  in  1  byte store (passed to mem_sb)
cpu_addr  in  AW  CPU byte address
cpu_wdata  in  DW  CPU store data
cpu_rdata  out  DW  load data, valid while CPU owns RD_WAIT
cpu_stall  out  1  freeze CPU pipeline; access not yet complete
dbg_req  in  1  debug access request
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  AW  debug byte address
dbg_wdata  in  DW  debug write data
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  debug read data valid this cycle
dbg_rdata  out  DW  debug read data
mem_we  out  1  memory write enable
mem_sb  out  1  memory byte-store select
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after the address is issued

Behaviour:
- States:
  - ARB_IDLE: arbitration; an access may be issued.
  - ARB_RDWAIT: a read is in flight. Owner register records CPU or DBG.
- Arbitration, ARB_IDLE only:
  - Debug wins if dbg_req && (!cpu_req || wait_cnt >= MAX_WAIT).
  - Otherwise CPU wins if cpu_req.
  - At most one access per cycle.
- Issue cycle (combinational from the winner):
  - mem_addr, mem_wdata, mem_we driven from the winner.
  - mem_sb = cpu_sb for CPU, 0 for debug.
  - Debug winner: dbg_gnt = 1.
- Write: completes in the issue cycle and the state stays ARB_IDLE.
  - CPU: cpu_stall = 0 that cycle.
  - Debug: dbg_gnt alone signals completion.
- Read: issue cycle -> ARB_RDWAIT with owner latched and address registered.
  - In ARB_RDWAIT, mem_addr holds the registered address and mem_we = 0.
  - Owner CPU: cpu_rdata = mem_rdata, cpu_stall = 0.
  - Owner DBG: dbg_rvalid = 1, dbg_rdata = mem_rdata.
  - Next state ARB_IDLE, so a read costs 2 cycles. No arbitration or issue in ARB_RDWAIT.
- cpu_stall = cpu_req && !(CPU write issued this cycle || ARB_RDWAIT with owner CPU).
  - CPU reads therefore stall exactly 1 cycle when uncontended.
- Outside their valid cycles: cpu_rdata, dbg_rdata = 0; dbg_gnt, dbg_rvalid = 0.
- With no grant: mem_we = 0, mem_sb = 0, mem_addr = 0, mem_wdata = 0.
- wait_cnt (8-bit):
  - Increments each ARB_IDLE cycle where dbg_req = 1 and debug loses.
  - Also increments each ARB_RDWAIT cycle where dbg_req = 1 and the owner is CPU.
  - Saturates at MAX_WAIT.
  - Clears on dbg_gnt or when dbg_req = 0.
- Requesters hold req/we/addr/wdata stable until completion.
  - A req drop during ARB_RDWAIT does not cancel the read; data is still presented for one cycle and may be ignored.
- Simultaneous cpu_req and dbg_req with wait_cnt < MAX_WAIT: CPU wins and debug waits.
- Reset, including mid-read:
  - Next cycle: state ARB_IDLE, wait_cnt = 0, owner = CPU, registered address = 0.
  - While reset is high: no grant, mem_we = 0, dbg_gnt = dbg_rvalid = 0, cpu_stall = cpu_req.
  - In-flight read data is discarded.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_RDWAIT} arb_state_t.
  - typedef enum logic {OWN_CPU, OWN_DBG} arb_owner_t.
  - Localparam WAIT_W = 8.
- One sub-module, arb_wait_counter: saturating counter with inc/clr inputs, MAX parameter and sat output.
- The FSM and muxing stay in dmem_arbiter.

Test Plan:
- CPU store only: cpu_req = 1, we = 1, sb = 0, addr 0x40, wdata 0xDEADBEEF -> same cycle mem_we = 1, mem_addr = 0x40, mem_wdata = 0xDEADBEEF, cpu_stall = 0.
- CPU load 0x40 with memory holding 0xDEADBEEF -> cycle 0: cpu_stall = 1, mem_addr = 0x40. Cycle 1: cpu_rdata = 0xDEADBEEF, cpu_stall = 0, then back to ARB_IDLE.
- Contention: cpu_req and dbg_req both held high with CPU stores and MAX_WAIT = 8 -> 8 consecutive CPU grants, then dbg_gnt = 1 on cycle 9 with cpu_stall = 1 that cycle, and wait_cnt returns to 0.
- Debug read 0x10 holding 0x12345678, CPU idle -> dbg_gnt cycle 0; dbg_rvalid = 1, dbg_rdata = 0x12345678 cycle 1. A CPU request arriving in cycle 1 stalls and is issued in cycle 2.
- CPU byte store: sb = 1, addr 0x43, wdata 0xAB -> mem_sb = 1, mem_we = 1. A debug write on the same cycle with wait_cnt = 0 is deferred (dbg_gnt = 0).
- Reset asserted during ARB_RDWAIT of a debug read -> dbg_rvalid = 0 and all mem_* = 0. After release, the next request sees ARB_IDLE with wait_cnt = 0.
